// File: rtl/minmax_pkg.sv
// Shared constants for the min/max selectors: default operand width and
// scheduler state encodings.
package minmax_pkg;

    localparam int unsigned WIDTH_DEF = 5;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACC  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/minmax_cmp_stage.sv
// Single shared comparator: flags whether a candidate replaces the running
// min and/or max. Strict compares keep the earliest occurrence on ties.
module minmax_cmp_stage
    import minmax_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] candidate,
    input  logic [WIDTH-1:0] cur_min,
    input  logic [WIDTH-1:0] cur_max,
    output logic             take_min,
    output logic             take_max
);

    assign take_min = (candidate < cur_min);
    assign take_max = (candidate > cur_max);

endmodule

// File: rtl/minmax_stream_sched.sv
// Time-multiplexed min/max scheduler: accumulates NUM words over a valid/ready
// stream and presents min, max and first-occurrence positions on its output.
module minmax_stream_sched
    import minmax_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned NUM   = 4,
    localparam int unsigned IDXW = $clog2(NUM)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_min,
    output logic [WIDTH-1:0] out_max,
    output logic [IDXW-1:0]  out_min_idx,
    output logic [IDXW-1:0]  out_max_idx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    // Count must be able to hold NUM itself after the final accept.
    localparam int unsigned CNTW = $clog2(NUM + 1);

    logic [1:0]       r_state;
    logic [CNTW-1:0]  r_count;
    logic [WIDTH-1:0] r_run_min;
    logic [WIDTH-1:0] r_run_max;
    logic [IDXW-1:0]  r_run_min_idx;
    logic [IDXW-1:0]  r_run_max_idx;
    logic [WIDTH-1:0] r_out_min;
    logic [WIDTH-1:0] r_out_max;
    logic [IDXW-1:0]  r_out_min_idx;
    logic [IDXW-1:0]  r_out_max_idx;

    logic             w_accept;
    logic             w_last;
    logic             w_take_min;
    logic             w_take_max;
    logic [IDXW-1:0]  w_pos;
    logic [WIDTH-1:0] w_nxt_min;
    logic [WIDTH-1:0] w_nxt_max;
    logic [IDXW-1:0]  w_nxt_min_idx;
    logic [IDXW-1:0]  w_nxt_max_idx;

    minmax_cmp_stage #(
        .WIDTH (WIDTH)
    ) u_cmp (
        .candidate (in_data),
        .cur_min   (r_run_min),
        .cur_max   (r_run_max),
        .take_min  (w_take_min),
        .take_max  (w_take_max)
    );

    assign in_ready  = (r_state == ST_IDLE) || (r_state == ST_ACC);
    assign busy      = (r_state == ST_ACC);
    assign out_valid = (r_state == ST_DONE);
    assign w_accept  = in_valid && in_ready;
    assign w_last    = (r_count == CNTW'(NUM - 1));
    assign w_pos     = r_count[IDXW-1:0];

    assign w_nxt_min     = w_take_min ? in_data : r_run_min;
    assign w_nxt_max     = w_take_max ? in_data : r_run_max;
    assign w_nxt_min_idx = w_take_min ? w_pos : r_run_min_idx;
    assign w_nxt_max_idx = w_take_max ? w_pos : r_run_max_idx;

    assign out_min     = r_out_min;
    assign out_max     = r_out_max;
    assign out_min_idx = r_out_min_idx;
    assign out_max_idx = r_out_max_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_count       <= '0;
            r_run_min     <= '0;
            r_run_max     <= '0;
            r_run_min_idx <= '0;
            r_run_max_idx <= '0;
            r_out_min     <= '0;
            r_out_max     <= '0;
            r_out_min_idx <= '0;
            r_out_max_idx <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_run_min     <= in_data;
                        r_run_max     <= in_data;
                        r_run_min_idx <= '0;
                        r_run_max_idx <= '0;
                        r_count       <= CNTW'(1);
                        r_state       <= ST_ACC;
                    end
                end
                ST_ACC: begin
                    if (w_accept) begin
                        r_run_min     <= w_nxt_min;
                        r_run_max     <= w_nxt_max;
                        r_run_min_idx <= w_nxt_min_idx;
                        r_run_max_idx <= w_nxt_max_idx;
                        r_count       <= r_count + CNTW'(1);
                        // Result registers load only here so outputs stay
                        // stable while the next group accumulates.
                        if (w_last) begin
                            r_out_min     <= w_nxt_min;
                            r_out_max     <= w_nxt_max;
                            r_out_min_idx <= w_nxt_min_idx;
                            r_out_max_idx <= w_nxt_max_idx;
                            r_state       <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_count <= '0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_count <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_minmax_stream_sched.sv
// Bench for minmax_stream_sched (WIDTH=5, NUM=4): directed scenarios plus
// random groups checked against a value-level reference model.
module tb_minmax_stream_sched;

    localparam int W = 5;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] out_min;
    logic [W-1:0] out_max;
    logic [1:0]   out_min_idx;
    logic [1:0]   out_max_idx;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic         busy;

    int n_total = 0;
    int n_pass  = 0;

    int prev_min = 0, prev_max = 0, prev_min_idx = 0, prev_max_idx = 0;

    minmax_stream_sched #(
        .WIDTH (W),
        .NUM   (N)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_min     (out_min),
        .out_max     (out_max),
        .out_min_idx (out_min_idx),
        .out_max_idx (out_max_idx),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
    endtask

    // Reference: extreme value first, then the lowest position holding it.
    task automatic model(input logic [N-1:0][W-1:0] w, output int mn, output int mx,
                         output int mni, output int mxi);
        mn = 31;
        mx = 0;
        for (int i = 0; i < N; i++) begin
            if (int'(w[i]) < mn) mn = int'(w[i]);
            if (int'(w[i]) > mx) mx = int'(w[i]);
        end
        mni = -1;
        mxi = -1;
        for (int i = 0; i < N; i++) begin
            if (mni < 0 && int'(w[i]) == mn) mni = i;
            if (mxi < 0 && int'(w[i]) == mx) mxi = i;
        end
    endtask

    task automatic push(input logic [W-1:0] d);
        int t = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) chk("push_ready_timeout", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic check_result(input string tag, input int mn, input int mx,
                                input int mni, input int mxi);
        chk({tag, "_min"}, out_min, mn);
        chk({tag, "_max"}, out_max, mx);
        chk({tag, "_min_idx"}, out_min_idx, mni);
        chk({tag, "_max_idx"}, out_max_idx, mxi);
    endtask

    // Stream one group; gap = idle cycles between words, hold = cycles of
    // out_ready=0 after out_valid, stuff = drive in_valid/30 during the hold.
    task automatic do_group(input string tag, input logic [N-1:0][W-1:0] w, input int gap,
                            input int hold, input bit stuff);
        int mn, mx, mni, mxi;
        model(w, mn, mx, mni, mxi);
        out_ready = (hold == 0);
        for (int i = 0; i < N; i++) begin
            if (i > 0) begin
                for (int g = 0; g < gap; g++) begin
                    @(negedge clk);
                    chk({tag, "_gap_busy"}, busy, 1);
                end
            end
            push(w[i]);
            if (i == 0) begin
                check_result({tag, "_prev"}, prev_min, prev_max, prev_min_idx, prev_max_idx);
                chk({tag, "_acc_busy"}, busy, 1);
            end
            if (i < N - 1) chk({tag, "_acc_valid"}, out_valid, 0);
        end
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_done_ready"}, in_ready, 0);
        chk({tag, "_done_busy"}, busy, 0);
        check_result(tag, mn, mx, mni, mxi);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (stuff) begin
                in_valid = 1'b1;
                in_data  = 5'd30;
            end
            chk({tag, "_hold_valid"}, out_valid, 1);
            chk({tag, "_hold_ready"}, in_ready, 0);
            check_result({tag, "_hold"}, mn, mx, mni, mxi);
        end
        if (hold > 0) begin
            @(negedge clk);
            out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        chk({tag, "_valid_drop"}, out_valid, 0);
        chk({tag, "_idle_ready"}, in_ready, 1);
        prev_min = mn;
        prev_max = mx;
        prev_min_idx = mni;
        prev_max_idx = mxi;
    endtask

    initial begin
        logic [N-1:0][W-1:0] w;
        int gap, hold;

        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        check_result("rst", 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 1);

        w = {5'd3, 5'd12, 5'd3, 5'd7};
        do_group("b2b", w, 0, 0, 1'b0);

        w = {5'd9, 5'd9, 5'd9, 5'd9};
        do_group("ties", w, 0, 0, 1'b0);

        w = {5'd0, 5'd31, 5'd31, 5'd0};
        do_group("extremes", w, 0, 0, 1'b0);

        w = {5'd8, 5'd1, 5'd20, 5'd5};
        do_group("bp", w, 0, 5, 1'b1);

        w = {5'd30, 5'd25, 5'd4, 5'd30};
        do_group("after_bp", w, 0, 0, 1'b0);

        w = {5'd1, 5'd6, 5'd2, 5'd4};
        do_group("gaps", w, 3, 0, 1'b0);

        push(5'd17);
        push(5'd2);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_ready", in_ready, 1);
        #2;
        rst_n = 1'b1;
        prev_min = 0;
        prev_max = 0;
        prev_min_idx = 0;
        prev_max_idx = 0;

        w = {5'd13, 5'd12, 5'd11, 5'd10};
        do_group("post_rst", w, 0, 0, 1'b0);

        for (int g = 0; g < 20; g++) begin
            for (int i = 0; i < N; i++) w[i] = W'($urandom_range(0, (g % 2) ? 31 : 3));
            gap  = $urandom_range(0, 2);
            hold = $urandom_range(0, 3);
            do_group("rand", w, gap, hold, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
